// File: rtl/nes_bus_pkg.sv
// Shared types for the NES CPU-side bus: arbiter states, slave identifiers and
// the address map that selects which slave answers a read.
package nes_bus_pkg;

    typedef enum logic [1:0] {IDLE, HALT, DMC, SPR} arb_state_e;

    typedef enum logic [2:0] {SL_RAM, SL_PPU, SL_APU, SL_JPD, SL_MMC} slave_e;

    localparam int NUM_SLAVES = 5;

    // Inclusive upper bound of each region; everything above JPD_LAST is cartridge space.
    localparam logic [15:0] RAM_LAST = 16'h1FFF;
    localparam logic [15:0] PPU_LAST = 16'h3FFF;
    localparam logic [15:0] APU_LAST = 16'h4015;
    localparam logic [15:0] JPD_LAST = 16'h4017;

    function automatic slave_e decode_slave(input logic [15:0] addr);
        if (addr <= RAM_LAST)      return SL_RAM;
        else if (addr <= PPU_LAST) return SL_PPU;
        else if (addr <= APU_LAST) return SL_APU;
        else if (addr <= JPD_LAST) return SL_JPD;
        else                       return SL_MMC;
    endfunction

endpackage

// File: rtl/nes_bus_rdmux.sv
// Combinational read-data mux: picks the slave byte selected by the bus address.
module nes_bus_rdmux
    import nes_bus_pkg::*;
(
    input  logic [15:0] addr,
    input  logic [7:0]  ram_rdata,
    input  logic [7:0]  ppu_rdata,
    input  logic [7:0]  apu_rdata,
    input  logic [7:0]  jpd_rdata,
    input  logic [7:0]  mmc_rdata,
    output logic [7:0]  rdata
);

    slave_e                slave;
    logic [NUM_SLAVES-1:0] sel;

    assign slave  = decode_slave(addr);
    assign sel[0] = (slave == SL_RAM);
    assign sel[1] = (slave == SL_PPU);
    assign sel[2] = (slave == SL_APU);
    assign sel[3] = (slave == SL_JPD);
    assign sel[4] = (slave == SL_MMC);

    // One-hot AND-OR per data bit keeps the mux flat.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign rdata[gi] = |(sel & {mmc_rdata[gi], jpd_rdata[gi], apu_rdata[gi],
                                        ppu_rdata[gi], ram_rdata[gi]});
        end
    endgenerate

endmodule

// File: rtl/nes_dma_arbiter.sv
// CPU-side bus owner: parks the 6502 and hands the bus to DMC sample fetches
// and OAM DMA streams, then routes the decoded read byte back to every consumer.
module nes_dma_arbiter
    import nes_bus_pkg::*;
#(
    parameter int HALT_CYCLES = 1,
    parameter bit DMC_PREEMPT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_r_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_pause,
    input  logic        i_dmc_req,
    output logic        o_dmc_gnt,
    input  logic [15:0] i_dmc_addr,
    output logic [7:0]  o_dmc_rdata,
    input  logic        i_spr_req,
    output logic        o_spr_gnt,
    input  logic [15:0] i_spr_addr,
    input  logic        i_spr_wn,
    input  logic [7:0]  i_spr_wdata,
    output logic [7:0]  o_spr_rdata,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    output logic        o_bus_wn,
    input  logic [7:0]  i_ram_rdata,
    input  logic [7:0]  i_ppu_rdata,
    input  logic [7:0]  i_apu_rdata,
    input  logic [7:0]  i_jpd_rdata,
    input  logic [7:0]  i_mmc_rdata
);

    localparam logic [1:0] HALT_LAST = 2'(HALT_CYCLES - 1);

    arb_state_e state_reg;
    logic [1:0] halt_cnt_reg;
    logic       pause_reg;
    logic       dmc_gnt_reg;
    logic       spr_gnt_reg;
    logic [7:0] bus_rdata;

    // Grants and pause are registered alongside the state so they line up with it exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            halt_cnt_reg <= '0;
            pause_reg    <= 1'b0;
            dmc_gnt_reg  <= 1'b0;
            spr_gnt_reg  <= 1'b0;
        end else begin
            dmc_gnt_reg <= 1'b0;
            spr_gnt_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Only a core read may be stalled; a pending write always completes first.
                    if ((i_dmc_req || i_spr_req) && i_cpu_r_wn) begin
                        state_reg    <= HALT;
                        halt_cnt_reg <= '0;
                        pause_reg    <= 1'b1;
                    end
                end
                HALT: begin
                    if (halt_cnt_reg == HALT_LAST) begin
                        halt_cnt_reg <= '0;
                        if (i_dmc_req) begin
                            state_reg   <= DMC;
                            dmc_gnt_reg <= 1'b1;
                        end else if (i_spr_req) begin
                            state_reg   <= SPR;
                            spr_gnt_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            pause_reg <= 1'b0;
                        end
                    end else begin
                        halt_cnt_reg <= halt_cnt_reg + 2'd1;
                    end
                end
                DMC: begin
                    if (i_spr_req) begin
                        state_reg   <= SPR;
                        spr_gnt_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        pause_reg <= 1'b0;
                    end
                end
                SPR: begin
                    if (DMC_PREEMPT && i_dmc_req) begin
                        state_reg   <= DMC;
                        dmc_gnt_reg <= 1'b1;
                    end else if (i_spr_req) begin
                        spr_gnt_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        pause_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    pause_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_bus_addr  = i_cpu_addr;
        o_bus_wdata = i_cpu_wdata;
        o_bus_wn    = i_cpu_r_wn;
        case (state_reg)
            HALT: o_bus_wn = 1'b1;
            DMC: begin
                o_bus_addr = i_dmc_addr;
                o_bus_wn   = 1'b1;
            end
            SPR: begin
                o_bus_addr  = i_spr_addr;
                o_bus_wdata = i_spr_wdata;
                o_bus_wn    = i_spr_wn;
            end
            default: ;
        endcase
    end

    nes_bus_rdmux u_rdmux (
        .addr      (o_bus_addr),
        .ram_rdata (i_ram_rdata),
        .ppu_rdata (i_ppu_rdata),
        .apu_rdata (i_apu_rdata),
        .jpd_rdata (i_jpd_rdata),
        .mmc_rdata (i_mmc_rdata),
        .rdata     (bus_rdata)
    );

    assign o_cpu_rdata = bus_rdata;
    assign o_dmc_rdata = bus_rdata;
    assign o_spr_rdata = bus_rdata;
    assign o_cpu_pause = pause_reg;
    assign o_dmc_gnt   = dmc_gnt_reg;
    assign o_spr_gnt   = spr_gnt_reg;

endmodule
